// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style 8-bit LCD bus sequencer:
// phase states, command bytes, the power-up init list and the long-command test.
package lcd_pkg;

   typedef enum logic [2:0] {
      POWERUP  = 3'd0,
      INIT_CMD = 3'd1,
      IDLE     = 3'd2,
      SETUP    = 3'd3,
      PULSE    = 3'd4,
      HOLD     = 3'd5,
      WAIT     = 3'd6
   } lcd_seq_state_t;

   localparam logic [7:0] LCD_CMD_FUNCSET_8B2L = 8'h38;
   localparam logic [7:0] LCD_CMD_DISP_ON      = 8'h0C;
   localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME         = 8'h02;
   localparam logic [7:0] LCD_CMD_ENTRY_INC    = 8'h06;

   localparam int INIT_LEN = 6;

   localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
      LCD_CMD_FUNCSET_8B2L,
      LCD_CMD_FUNCSET_8B2L,
      LCD_CMD_FUNCSET_8B2L,
      LCD_CMD_DISP_ON,
      LCD_CMD_CLEAR,
      LCD_CMD_ENTRY_INC
   };

   // Clear and both home encodings (bit 0 of home is don't-care) need the long wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd);
      return !rs && (cmd == LCD_CMD_CLEAR || cmd == LCD_CMD_HOME || cmd == 8'h03);
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Shared down-counter for every sequencer phase: load with length-1, done at zero.
// Comes out of reset already loaded for the power-up wait.
module lcd_phase_timer #(
   parameter int               CNT_W       = 20,
   parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RESET_VALUE;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Drives the HD44780 8-bit bus: power-up wait, fixed init list, then one byte per
// valid/ready handshake with RS/DATA setup, E pulse, hold and execution wait.
module lcd_bus_sequencer
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYCLES    = 750_000,
   parameter int EN_SETUP_CYCLES   = 2,
   parameter int EN_PULSE_CYCLES   = 25,
   parameter int EN_HOLD_CYCLES    = 2,
   parameter int FIRST_WAIT_CYCLES = 205_000,
   parameter int SHORT_WAIT_CYCLES = 2_500,
   parameter int LONG_WAIT_CYCLES  = 82_000,
   parameter int CNT_W             = 20
) (
   input  logic       fpga_clk_i,
   input  logic       fpga_reset_i,
   input  logic       req_valid_i,
   input  logic       req_rs_i,
   input  logic [7:0] req_data_i,
   output logic       req_ready_o,
   output logic       init_done_o,
   output logic       busy_o,
   output logic [7:0] lcd_data_o,
   output logic       lcd_reset_o,
   output logic       lcd_enable_o
);

   // Handshake: a byte transfers on a cycle where req_valid_i and req_ready_o are
   // both high; the requester holds valid/rs/data stable until that cycle.

   localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(EN_SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(EN_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(EN_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_FIRST   = CNT_W'(FIRST_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_SHORT   = CNT_W'(SHORT_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_LONG    = CNT_W'(LONG_WAIT_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX   = 3'(INIT_LEN - 1);

   lcd_seq_state_t   state, state_n;
   logic [2:0]       idx, idx_n;
   logic             init_done_n;
   logic [7:0]       data_n;
   logic             rs_n;
   logic             ready_n;
   logic             t_load;
   logic [CNT_W-1:0] t_value;
   logic             t_done;

   lcd_phase_timer #(
      .CNT_W       (CNT_W),
      .RESET_VALUE (LD_POWERUP)
   ) u_timer (
      .clk   (fpga_clk_i),
      .reset (fpga_reset_i),
      .load  (t_load),
      .value (t_value),
      .done  (t_done)
   );

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      init_done_n = init_done_o;
      data_n      = lcd_data_o;
      rs_n        = lcd_reset_o;
      t_load      = 1'b0;
      t_value     = LD_SETUP;
      case (state)
         POWERUP: begin
            if (t_done) state_n = INIT_CMD;
         end
         INIT_CMD: begin
            data_n  = INIT_ROM[idx];
            rs_n    = 1'b0;
            state_n = SETUP;
            t_load  = 1'b1;
            t_value = LD_SETUP;
         end
         IDLE: begin
            if (req_valid_i && req_ready_o) begin
               data_n  = req_data_i;
               rs_n    = req_rs_i;
               state_n = SETUP;
               t_load  = 1'b1;
               t_value = LD_SETUP;
            end
         end
         SETUP: begin
            if (t_done) begin
               state_n = PULSE;
               t_load  = 1'b1;
               t_value = LD_PULSE;
            end
         end
         PULSE: begin
            if (t_done) begin
               state_n = HOLD;
               t_load  = 1'b1;
               t_value = LD_HOLD;
            end
         end
         HOLD: begin
            if (t_done) begin
               state_n = WAIT;
               t_load  = 1'b1;
               // The first function-set after power-up needs the extra-long settle.
               if (!init_done_o && idx == 3'd0) t_value = LD_FIRST;
               else if (is_long_cmd(lcd_reset_o, lcd_data_o)) t_value = LD_LONG;
               else t_value = LD_SHORT;
            end
         end
         WAIT: begin
            if (t_done) begin
               if (init_done_o) begin
                  state_n = IDLE;
               end else if (idx == LAST_IDX) begin
                  init_done_n = 1'b1;
                  state_n     = IDLE;
               end else begin
                  idx_n   = idx + 3'd1;
                  state_n = INIT_CMD;
               end
            end
         end
         default: state_n = POWERUP;
      endcase
   end

   assign ready_n = (state_n == IDLE) && init_done_n;

   // Outputs are computed from the next state so every pin is a flop.
   always_ff @(posedge fpga_clk_i) begin
      if (fpga_reset_i) begin
         state        <= POWERUP;
         idx          <= 3'd0;
         init_done_o  <= 1'b0;
         lcd_data_o   <= 8'h00;
         lcd_reset_o  <= 1'b0;
         lcd_enable_o <= 1'b0;
         req_ready_o  <= 1'b0;
         busy_o       <= 1'b1;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         init_done_o  <= init_done_n;
         lcd_data_o   <= data_n;
         lcd_reset_o  <= rs_n;
         lcd_enable_o <= (state_n == PULSE);
         req_ready_o  <= ready_n;
         busy_o       <= !ready_n;
      end
   end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer with short simulation timings:
// init replay, table of single writes, held-valid, back-to-back and mid-pulse reset.
module tb_lcd_bus_sequencer;

   localparam int POWERUP = 10;
   localparam int S       = 2;
   localparam int P       = 3;
   localparam int H       = 1;
   localparam int FIRST   = 8;
   localparam int SHORT   = 5;
   localparam int LONG    = 20;
   localparam int LAT_SHORT      = 12;
   localparam int LAT_LONG       = 27;
   localparam int INIT_DONE_EDGE = 100;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic       rs = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready, init_done, busy, lcd_rs, lcd_enable;
   logic [7:0] lcd_data;

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;
   logic       prev_e = 1'b0;
   logic [8:0] pulse_word = '0;
   logic [8:0] exp_q[$];

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         lat;
   } vec_t;

   vec_t vecs[9];

   lcd_bus_sequencer #(
      .POWERUP_CYCLES    (POWERUP),
      .EN_SETUP_CYCLES   (S),
      .EN_PULSE_CYCLES   (P),
      .EN_HOLD_CYCLES    (H),
      .FIRST_WAIT_CYCLES (FIRST),
      .SHORT_WAIT_CYCLES (SHORT),
      .LONG_WAIT_CYCLES  (LONG),
      .CNT_W             (20)
   ) dut (
      .fpga_clk_i   (clk),
      .fpga_reset_i (reset),
      .req_valid_i  (valid),
      .req_rs_i     (rs),
      .req_data_i   (data),
      .req_ready_o  (ready),
      .init_done_o  (init_done),
      .busy_o       (busy),
      .lcd_data_o   (lcd_data),
      .lcd_reset_o  (lcd_rs),
      .lcd_enable_o (lcd_enable)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard: every E rising edge must carry the oldest expected {rs,data};
   // while E stays high the bus must not move.
   always @(negedge clk) begin
      if (lcd_enable && !prev_e) begin
         pulse_cnt++;
         pulse_word = {lcd_rs, lcd_data};
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got %0h, required no pulse (t=%0t)", pulse_word, $time);
         end else begin
            check("pulse_byte", 32'(pulse_word), 32'(exp_q.pop_front()));
         end
      end else if (lcd_enable && prev_e) begin
         check("e_high_bus_stable", 32'({lcd_rs, lcd_data}), 32'(pulse_word));
      end
      prev_e = lcd_enable;
   end

   task automatic wait_ready(input int budget, output logic ok);
      int n;
      n  = 0;
      ok = 1'b0;
      while (!ok && n <= budget) begin
         if (ready) ok = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
   endtask

   task automatic reset_and_init();
      logic bad_early;
      reset = 1'b1;
      valid = 1'b0;
      @(negedge clk);
      check("rst_enable", 32'(lcd_enable), 32'd0);
      check("rst_data", 32'(lcd_data), 32'h00);
      check("rst_rs", 32'(lcd_rs), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      exp_q.delete();
      pulse_cnt = 0;
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
      bad_early = 1'b0;
      for (int k = 1; k < INIT_DONE_EDGE; k++) begin
         @(negedge clk);
         if (ready || init_done || !busy) bad_early = 1'b1;
      end
      @(negedge clk);
      check("no_ready_before_init", 32'(bad_early), 32'd0);
      check("init_done_at_edge", 32'(init_done), 32'd1);
      check("ready_after_init", 32'(ready), 32'd1);
      check("busy_after_init", 32'(busy), 32'd0);
      check("init_pulse_count", 32'(pulse_cnt), 32'd6);
      check("init_queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic send(input logic r, input logic [7:0] d, input int exp_lat);
      logic ok, pins_ok, e_ok;
      int   n;
      valid = 1'b1;
      rs    = r;
      data  = d;
      wait_ready(200, ok);
      check("send_ready_seen", 32'(ok), 32'd1);
      if (ok) begin
         exp_q.push_back({r, d});
         pins_ok = 1'b1;
         e_ok    = 1'b1;
         n       = 0;
         for (int k = 1; k <= exp_lat + 5; k++) begin
            @(negedge clk);
            if (k == 1) valid = 1'b0;
            if (ready) begin
               n = k;
               break;
            end
            if ({lcd_rs, lcd_data} != {r, d}) pins_ok = 1'b0;
            if (lcd_enable != (k > S && k <= S + P)) e_ok = 1'b0;
         end
         check("ready_latency", 32'(n), 32'(exp_lat));
         check("pins_stable", 32'(pins_ok), 32'd1);
         check("e_window", 32'(e_ok), 32'd1);
      end
      valid = 1'b0;
   endtask

   initial begin
      logic ok, got;
      int   p0, lat;

      vecs[0] = '{1'b1, 8'h41, LAT_SHORT};
      vecs[1] = '{1'b0, 8'h01, LAT_LONG};
      vecs[2] = '{1'b1, 8'h01, LAT_SHORT};
      vecs[3] = '{1'b0, 8'h02, LAT_LONG};
      vecs[4] = '{1'b0, 8'h03, LAT_LONG};
      vecs[5] = '{1'b0, 8'h04, LAT_SHORT};
      vecs[6] = '{1'b0, 8'h38, LAT_SHORT};
      vecs[7] = '{1'b1, 8'h02, LAT_SHORT};
      vecs[8] = '{1'b0, 8'h00, LAT_SHORT};

      repeat (2) @(negedge clk);
      reset_and_init();

      foreach (vecs[i]) send(vecs[i].rs, vecs[i].data, vecs[i].lat);

      // Valid held through busy, data scrambled each cycle: only handshake bytes pulse.
      p0    = pulse_cnt;
      valid = 1'b1;
      rs    = 1'b1;
      data  = 8'($urandom_range(0, 255));
      for (int h = 0; h < 3; h++) begin
         got = 1'b0;
         for (int k = 0; k < 200 && !got; k++) begin
            if (ready) begin
               exp_q.push_back({1'b1, data});
               got = 1'b1;
            end else begin
               data = 8'($urandom_range(0, 255));
               @(negedge clk);
            end
         end
         check("held_valid_handshake", 32'(got), 32'd1);
         @(negedge clk);
         data = 8'($urandom_range(0, 255));
      end
      valid = 1'b0;
      wait_ready(200, ok);
      check("held_valid_idle", 32'(ok), 32'd1);
      check("held_valid_pulses", 32'(pulse_cnt - p0), 32'd3);
      check("held_valid_queue", 32'(exp_q.size()), 32'd0);

      // Back-to-back: 0x49 must be taken on the very first ready cycle.
      valid = 1'b1;
      rs    = 1'b1;
      data  = 8'h48;
      wait_ready(200, ok);
      check("b2b_first_ready", 32'(ok), 32'd1);
      exp_q.push_back({1'b1, 8'h48});
      @(negedge clk);
      data = 8'h49;
      lat  = 0;
      for (int k = 1; k <= 40; k++) begin
         if (ready) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      check("b2b_second_latency", 32'(lat), 32'(LAT_SHORT));
      exp_q.push_back({1'b1, 8'h49});
      @(negedge clk);
      valid = 1'b0;
      wait_ready(200, ok);
      check("b2b_done", 32'(ok), 32'd1);
      check("b2b_queue", 32'(exp_q.size()), 32'd0);

      // Reset while E is high: E drops next cycle and init replays.
      valid = 1'b1;
      rs    = 1'b1;
      data  = 8'h5A;
      wait_ready(200, ok);
      exp_q.push_back({1'b1, 8'h5A});
      @(negedge clk);
      valid = 1'b0;
      for (int k = 0; k < 50 && !lcd_enable; k++) @(negedge clk);
      check("e_seen_before_reset", 32'(lcd_enable), 32'd1);
      reset_and_init();

      send(1'b1, 8'h41, LAT_SHORT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
